// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory controller:
//   - access size codes carried on req_size
//   - controller FSM state encoding
//   - helpers for the store byte strobes, store lane replication,
//     load lane extraction/extension and alignment checking
// All data paths are 32 bits wide with four byte lanes, little-endian.
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RESP
  } state_e;

  // True when the size code is illegal or the byte lane is not naturally
  // aligned for the access size.
  function automatic logic is_misaligned(size_e size, logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-lane write strobe for a store of the given size at the given lane.
  function automatic logic [LANES-1:0] gen_strobe(size_e size, logic [1:0] lane);
    logic [LANES-1:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << lane;
      SZ_HALF: strb = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Store data arrives right-justified; replicate it across the word so the
  // strobe alone selects which lanes take it.
  function automatic logic [WORD_W-1:0] gen_wdata(size_e size, logic [WORD_W-1:0] wdata);
    logic [WORD_W-1:0] data;
    case (size)
      SZ_BYTE: data = {4{wdata[7:0]}};
      SZ_HALF: data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

  // Shift the addressed lane down to bit 0 and sign/zero extend it.
  // Word loads ignore the signed flag.
  function automatic logic [WORD_W-1:0] load_extend(logic [WORD_W-1:0] word,
                                                    size_e size,
                                                    logic [1:0] lane,
                                                    logic sgn);
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] result;
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit word storage with per-byte write strobes and a registered
// read port. Writes and reads both take effect at the rising clock edge; the
// read register only updates when re is high, so the last read word stays
// on rdata until the next read.
// Ports:
//   clk    - clock
//   we     - write enable
//   strb   - byte-lane write strobes (bit n enables bits [8n+7:8n])
//   addr   - word index, shared by read and write
//   wdata  - write data (already replicated to the strobed lanes)
//   re     - read enable
//   rdata  - registered read data
// -----------------------------------------------------------------------------
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LANES-1:0]  strb,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] rdata_d;

  // Only strobed lanes are written; the rest of the word keeps its value.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < LANES; b++) begin
        if (strb[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read data is held until the next enabled read.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Byte-addressed, little-endian data memory for the CPU load/store path.
// Supports byte/half/word loads and stores with alignment, size and range
// checking, sign/zero extension on loads, and a post-reset clear sweep that
// zeroes one word per cycle.
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   req_valid/req_ready   - request handshake (one outstanding access)
//   req_we                - 1 = store, 0 = load
//   req_size              - 00 byte, 01 half, 10 word, 11 illegal
//   req_signed            - sign-extend loads (byte/half only)
//   req_addr              - byte address
//   req_wdata             - right-justified store data
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata             - extended load data; 0 for stores and errors
//   rsp_err               - misaligned, illegal size or out-of-range access
//   busy                  - clear sweep in progress
// -----------------------------------------------------------------------------
module dmem_ctrl import dmem_pkg::*; #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_ctrl: DATA_W must be 32");
  end
  if (DEPTH > (1 << IDX_W)) begin : g_bad_depth
    $error("dmem_ctrl: DEPTH exceeds the word-addressable range of ADDR_W");
  end

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_load_q, rsp_load_d;
  logic [1:0]       lane_q, lane_d;
  size_e            size_q, size_d;
  logic             signed_q, signed_d;

  size_e            dec_size;
  logic [1:0]       dec_lane;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_range_err;
  logic             dec_err;
  logic             accept;

  logic             arr_we;
  logic             arr_re;
  logic [LANES-1:0] arr_strb;
  logic [AW-1:0]    arr_addr;
  logic [31:0]      arr_wdata;
  logic [31:0]      arr_rdata;

  // Request decode. The range check is done on the full word index so that
  // addresses beyond DEPTH never alias onto real words.
  assign dec_size      = size_e'(req_size);
  assign dec_lane      = req_addr[1:0];
  assign dec_idx       = req_addr[ADDR_W-1:2];
  assign dec_range_err = ({1'b0, dec_idx} >= (IDX_W+1)'(DEPTH));
  assign dec_err       = is_misaligned(dec_size, dec_lane) || dec_range_err;
  assign accept        = req_valid && req_ready_q;

  // Next-state logic. The array port is shared: the clear sweep owns it in
  // ST_CLEAR, an accepted request owns it in ST_IDLE. Loads read the array at
  // the accept edge and the read register then holds the word for the whole
  // response phase, so only the lane/size/sign need capturing here.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    rsp_err_d  = rsp_err_q;
    rsp_load_d = rsp_load_q;
    lane_d     = lane_q;
    size_d     = size_q;
    signed_d   = signed_q;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    arr_strb   = '0;
    arr_addr   = clr_idx_q;
    arr_wdata  = '0;

    case (state_q)
      ST_CLEAR: begin
        arr_we   = 1'b1;
        arr_strb = 4'b1111;
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          clr_idx_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end

      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_RESP;
          rsp_err_d  = dec_err;
          rsp_load_d = !req_we && !dec_err;
          lane_d     = dec_lane;
          size_d     = dec_size;
          signed_d   = req_signed;
          arr_addr   = dec_idx[AW-1:0];
          if (!dec_err) begin
            if (req_we) begin
              arr_we    = 1'b1;
              arr_strb  = gen_strobe(dec_size, dec_lane);
              arr_wdata = gen_wdata(dec_size, req_wdata);
            end else begin
              arr_re = 1'b1;
            end
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and response-context registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_idx_q   <= '0;
      req_ready_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      lane_q      <= 2'b00;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      req_ready_q <= req_ready_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
    end
  end

  // Array accesses are suppressed on a reset edge so that neither a clear
  // write nor a request write can land while reset is asserted.
  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we & reset_n),
    .strb  (arr_strb),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .re    (arr_re & reset_n),
    .rdata (arr_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q == ST_CLEAR);
  assign rsp_err   = rsp_valid && rsp_err_q;
  assign rsp_rdata = (rsp_valid && rsp_load_q)
                     ? load_extend(arr_rdata, size_q, lane_q, signed_q)
                     : 32'h0000_0000;

endmodule
